// File: rtl/csr_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : csr_access_unit_if
//  Purpose  : Bundles the EX-side request/response handshake, the flush line
//             and the CSR array strobes used by csr_access_unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface csr_access_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // EX request channel
  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_op_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_src_i;
  logic              req_src_zero_i;
  logic              req_illegal_i;
  logic              flush_i;

  // CSR array side
  logic [ADDR_W-1:0] csr_addr_o;
  logic              csr_re_o;
  logic [DATA_W-1:0] csr_rdata_i;
  logic              csr_we_o;
  logic [DATA_W-1:0] csr_wdata_o;

  // Response channel
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DATA_W-1:0] resp_rdata_o;
  logic              resp_err_o;

  // The access unit itself
  modport slave (
    input  req_valid_i, req_op_i, req_addr_i, req_src_i, req_src_zero_i,
           req_illegal_i, flush_i, csr_rdata_i, resp_ready_i,
    output req_ready_o, csr_addr_o, csr_re_o, csr_we_o, csr_wdata_o,
           resp_valid_o, resp_rdata_o, resp_err_o
  );

  // The surrounding pipeline / CSR array
  modport master (
    output req_valid_i, req_op_i, req_addr_i, req_src_i, req_src_zero_i,
           req_illegal_i, flush_i, csr_rdata_i, resp_ready_i,
    input  req_ready_o, csr_addr_o, csr_re_o, csr_we_o, csr_wdata_o,
           resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface
`default_nettype wire

// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : csr_access_unit
//  Purpose  : Executes Zicsr read-modify-write operations (CSRRW/RS/RC and
//             immediate forms) against the CSR array and returns the old value.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_access_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  csr_access_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] c_OP_RW = 2'b01;
  localparam logic [1:0] c_OP_RS = 2'b10;
  localparam logic [1:0] c_OP_RC = 2'b11;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_src;
  logic [DATA_W-1:0] r_old;
  logic              r_wen;
  logic              r_err;

  logic              w_accept;
  logic              w_req_wen;
  logic              w_req_err;
  logic [DATA_W-1:0] w_wdata;

  // A set/clear with a zero mask is a pure read; swap always writes.
  assign w_req_wen = (bus.req_op_i == c_OP_RW) |
                     (((bus.req_op_i == c_OP_RS) | (bus.req_op_i == c_OP_RC)) &
                      ~bus.req_src_zero_i);

  // Address bits [11:10]==2'b11 mark the read-only CSR space.
  assign w_req_err = bus.req_illegal_i | (bus.req_op_i == 2'b00) |
                     ((bus.req_addr_i[ADDR_W-1 -: 2] == 2'b11) & w_req_wen);

  assign w_accept = (r_state == ST_IDLE) & bus.req_valid_i & ~bus.flush_i;

  // State register; reset drops any in-flight operation immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the request on acceptance and capture the old CSR value in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= 2'b00;
      r_addr <= '0;
      r_src  <= '0;
      r_old  <= '0;
      r_wen  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= bus.req_op_i;
      r_addr <= bus.req_addr_i;
      r_src  <= bus.req_src_i;
      r_old  <= '0;
      r_wen  <= w_req_wen;
      r_err  <= w_req_err;
    end else if ((r_state == ST_READ) && !bus.flush_i) begin
      r_old  <= bus.csr_rdata_i;
    end
  end

  // New CSR value from the old value and the source operand.
  always_comb begin
    w_wdata = r_src;
    case (r_op)
      c_OP_RS: w_wdata = r_old | r_src;
      c_OP_RC: w_wdata = r_old & ~r_src;
      default: w_wdata = r_src;
    endcase
  end

  // Next-state and output decode; a flush aborts and suppresses all strobes.
  always_comb begin
    w_next           = r_state;
    bus.req_ready_o  = 1'b0;
    bus.csr_addr_o   = '0;
    bus.csr_re_o     = 1'b0;
    bus.csr_we_o     = 1'b0;
    bus.csr_wdata_o  = '0;
    bus.resp_valid_o = 1'b0;
    bus.resp_rdata_o = '0;
    bus.resp_err_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready_o = ~bus.flush_i;
        if (w_accept) begin
          w_next = w_req_err ? ST_RESP : ST_READ;
        end
      end
      ST_READ: begin
        if (bus.flush_i) begin
          w_next = ST_IDLE;
        end else begin
          bus.csr_re_o   = 1'b1;
          bus.csr_addr_o = r_addr;
          w_next         = r_wen ? ST_WRITE : ST_RESP;
        end
      end
      ST_WRITE: begin
        if (bus.flush_i) begin
          w_next = ST_IDLE;
        end else begin
          bus.csr_we_o    = 1'b1;
          bus.csr_addr_o  = r_addr;
          bus.csr_wdata_o = w_wdata;
          w_next          = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.flush_i) begin
          w_next = ST_IDLE;
        end else begin
          bus.resp_valid_o = 1'b1;
          bus.resp_rdata_o = r_err ? '0 : r_old;
          bus.resp_err_o   = r_err;
          if (bus.resp_ready_i) begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_access_unit
//  Purpose  : Directed, table-driven self-checking bench for csr_access_unit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_access_unit;

  logic clk;
  logic rst_n;

  csr_access_unit_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  csr_access_unit #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR array model: combinational read, write on clock edge.
  logic [31:0] mem [0:4095];
  assign bus.csr_rdata_i = mem[bus.csr_addr_o];

  int          checks;
  int          failures;
  int          re_cnt;
  int          we_cnt;
  int          gate_viol;
  logic [31:0] last_wdata;

  // Strobe monitor and array write port.
  always @(posedge clk) begin
    if (bus.csr_re_o) re_cnt <= re_cnt + 1;
    if (bus.csr_we_o) begin
      we_cnt     <= we_cnt + 1;
      last_wdata <= bus.csr_wdata_o;
      mem[bus.csr_addr_o] <= bus.csr_wdata_o;
    end
  end

  // Address/data must read zero whenever the matching strobe is low.
  always @(negedge clk) begin
    if (!bus.csr_re_o && !bus.csr_we_o && bus.csr_addr_o != 12'h0) gate_viol <= gate_viol + 1;
    if (!bus.csr_we_o && bus.csr_wdata_o != 32'h0) gate_viol <= gate_viol + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] src;
    logic        src_zero;
    logic        illegal;
    logic [31:0] init;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_re;
    int          exp_we;
    logic [31:0] exp_wdata;
    int          exp_lat;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs [11];

  task automatic drive_req(input logic [1:0] op, input logic [11:0] addr,
                           input logic [31:0] src, input logic sz, input logic ill);
    bus.req_valid_i    = 1'b1;
    bus.req_op_i       = op;
    bus.req_addr_i     = addr;
    bus.req_src_i      = src;
    bus.req_src_zero_i = sz;
    bus.req_illegal_i  = ill;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int re0;
    int we0;
    int lat;
    string tag;
    tag = $sformatf("v%0d", idx);
    mem[v.addr] = v.init;
    @(negedge clk);
    re0 = re_cnt;
    we0 = we_cnt;
    drive_req(v.op, v.addr, v.src, v.src_zero, v.illegal);
    #1;
    chk({tag, "_req_ready"}, {31'b0, bus.req_ready_o}, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid_o && lat < 10);
    chk({tag, "_latency"}, lat, v.exp_lat);
    chk({tag, "_resp_rdata"}, bus.resp_rdata_o, v.exp_rdata);
    chk({tag, "_resp_err"}, {31'b0, bus.resp_err_o}, {31'b0, v.exp_err});
    bus.resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready_i = 1'b0;
    chk({tag, "_re_count"}, re_cnt - re0, v.exp_re);
    chk({tag, "_we_count"}, we_cnt - we0, v.exp_we);
    if (v.exp_we != 0) chk({tag, "_wdata"}, last_wdata, v.exp_wdata);
    chk({tag, "_array"}, mem[v.addr], v.exp_final);
    chk({tag, "_post_valid"}, {31'b0, bus.resp_valid_o}, 32'h0);
    chk({tag, "_post_ready"}, {31'b0, bus.req_ready_o}, 32'h1);
  endtask

  initial begin
    checks = 0; failures = 0;
    re_cnt = 0; we_cnt = 0; gate_viol = 0; last_wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    bus.req_valid_i = 1'b0; bus.req_op_i = 2'b00; bus.req_addr_i = '0;
    bus.req_src_i = '0; bus.req_src_zero_i = 1'b0; bus.req_illegal_i = 1'b0;
    bus.flush_i = 1'b0; bus.resp_ready_i = 1'b0;

    //          op     addr    src           sz    ill   init          rdata         err  re we wdata         lat final
    vecs[0]  = '{2'b01, 12'h340, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00000001, 32'h00000001, 1'b0, 1, 1, 32'hDEADBEEF, 3, 32'hDEADBEEF};
    vecs[1]  = '{2'b10, 12'h300, 32'h000000F0, 1'b0, 1'b0, 32'h0000000F, 32'h0000000F, 1'b0, 1, 1, 32'h000000FF, 3, 32'h000000FF};
    vecs[2]  = '{2'b11, 12'h300, 32'h0000000F, 1'b0, 1'b0, 32'h000000FF, 32'h000000FF, 1'b0, 1, 1, 32'h000000F0, 3, 32'h000000F0};
    vecs[3]  = '{2'b10, 12'h305, 32'h00000000, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 1'b0, 1, 0, 32'h0,        2, 32'h12345678};
    vecs[4]  = '{2'b01, 12'hC00, 32'h00000005, 1'b0, 1'b0, 32'h0000AAAA, 32'h00000000, 1'b1, 0, 0, 32'h0,        1, 32'h0000AAAA};
    vecs[5]  = '{2'b10, 12'hC00, 32'h00000000, 1'b1, 1'b0, 32'h00000077, 32'h00000077, 1'b0, 1, 0, 32'h0,        2, 32'h00000077};
    vecs[6]  = '{2'b00, 12'h340, 32'h00000011, 1'b0, 1'b0, 32'h00000022, 32'h00000000, 1'b1, 0, 0, 32'h0,        1, 32'h00000022};
    vecs[7]  = '{2'b01, 12'h341, 32'h00000033, 1'b0, 1'b1, 32'h00000044, 32'h00000000, 1'b1, 0, 0, 32'h0,        1, 32'h00000044};
    vecs[8]  = '{2'b11, 12'h344, 32'h00000000, 1'b1, 1'b0, 32'h00000055, 32'h00000055, 1'b0, 1, 0, 32'h0,        2, 32'h00000055};
    vecs[9]  = '{2'b11, 12'hC01, 32'h00000001, 1'b0, 1'b0, 32'h00000066, 32'h00000000, 1'b1, 0, 0, 32'h0,        1, 32'h00000066};
    vecs[10] = '{2'b01, 12'hC02, 32'h00000000, 1'b1, 1'b0, 32'h00000088, 32'h00000000, 1'b1, 0, 0, 32'h0,        1, 32'h00000088};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, bus.req_ready_o}, 32'h1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid_o}, 32'h0);
    chk("rst_strobes", {30'b0, bus.csr_re_o, bus.csr_we_o}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata_o, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Flush while idle blocks acceptance
    @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    chk("idle_flush_ready", {31'b0, bus.req_ready_o}, 32'h0);
    @(negedge clk);
    bus.flush_i = 1'b0;

    // Flush during WRITE: no write, no response, ready again next cycle
    mem[12'h350] = 32'h00000009;
    we_cnt = we_cnt;
    begin
      int we0;
      we0 = we_cnt;
      drive_req(2'b01, 12'h350, 32'h00001234, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      chk("fl_read_re", {31'b0, bus.csr_re_o}, 32'h1);
      @(negedge clk);
      bus.flush_i = 1'b1;
      #1;
      chk("fl_write_we", {31'b0, bus.csr_we_o}, 32'h0);
      @(negedge clk);
      bus.flush_i = 1'b0;
      #1;
      chk("fl_ready_after", {31'b0, bus.req_ready_o}, 32'h1);
      chk("fl_no_resp", {31'b0, bus.resp_valid_o}, 32'h0);
      repeat (3) begin
        @(negedge clk);
        chk("fl_resp_dropped", {31'b0, bus.resp_valid_o}, 32'h0);
      end
      chk("fl_we_count", we_cnt - we0, 0);
      chk("fl_array", mem[12'h350], 32'h00000009);
    end

    // Backpressure: response held stable, no new request accepted
    mem[12'h360] = 32'h00000042;
    begin
      int lat;
      drive_req(2'b01, 12'h360, 32'h0000CAFE, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive_req(2'b10, 12'h361, 32'h1, 1'b0, 1'b0);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!bus.resp_valid_o && lat < 10);
      chk("bp_latency", lat, 3);
      for (int k = 0; k < 5; k++) begin
        chk("bp_valid_hold", {31'b0, bus.resp_valid_o}, 32'h1);
        chk("bp_rdata_hold", bus.resp_rdata_o, 32'h00000042);
        chk("bp_ready_low", {31'b0, bus.req_ready_o}, 32'h0);
        @(negedge clk);
      end
      bus.resp_ready_i = 1'b1;
      #1;
      chk("bp_ready_at_hs", {31'b0, bus.req_ready_o}, 32'h0);
      @(posedge clk); #1;
      bus.resp_ready_i = 1'b0;
      bus.req_valid_i  = 1'b0;
      chk("bp_done_valid", {31'b0, bus.resp_valid_o}, 32'h0);
      chk("bp_done_ready", {31'b0, bus.req_ready_o}, 32'h1);
      chk("bp_array", mem[12'h360], 32'h0000CAFE);
      chk("bp_untouched", mem[12'h361], 32'h00000000);
    end

    // Reset during WRITE: no write issued, unit returns to idle
    mem[12'h370] = 32'h00000003;
    begin
      int we0;
      we0 = we_cnt;
      @(negedge clk);
      drive_req(2'b01, 12'h370, 32'h0000BEEF, 1'b0, 1'b0);
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rr_we_low", {31'b0, bus.csr_we_o}, 32'h0);
      chk("rr_ready", {31'b0, bus.req_ready_o}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rr_no_resp", {31'b0, bus.resp_valid_o}, 32'h0);
      chk("rr_we_count", we_cnt - we0, 0);
      chk("rr_array", mem[12'h370], 32'h00000003);
    end

    chk("strobe_gating", gate_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
